// File: rtl/val2_shift_ctrl.sv
// val2_shift_ctrl: registered Val2 shifter with a request handshake that waits for Rs when needed.
// Define VAL2_SHIFT_CARRY_EN to produce a real carry_out; otherwise carry_out is tied to 0.
module val2_shift_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] val_rm,
  input  logic [11:0] shift_operand,
  input  logic        imm,
  input  logic        mem_op,
  input  logic        reg_shift,
  input  logic        carry_in,
  input  logic [31:0] rs_value,
  input  logic        rs_valid,
  input  logic        out_ready,
  output logic [31:0] val2,
  output logic        val2_valid,
  output logic        carry_out,
  output logic        stall
);
  typedef enum logic [1:0] {IDLE, WAIT_RS, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] rm_q, rm_d, val2_q, val2_d;
  logic [11:0] op_q, op_d;
  logic        imm_q, imm_d, mem_q, mem_d, rsh_q, rsh_d, cin_q, cin_d;
  logic        carry_q, carry_d;
  logic        acc, load, rsh_live, cin_live;
  logic [32:0] sh;
  logic [23:0] unused_rs_hi;

  assign unused_rs_hi = rs_value[31:8];

`ifdef VAL2_SHIFT_CARRY_EN
  localparam logic CARRY_EN = 1'b1;
  assign cin_live = carry_in;
`else
  localparam logic CARRY_EN = 1'b0;
  logic unused_carry_in;
  assign unused_carry_in = carry_in;
  assign cin_live = 1'b0;
`endif

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] k);
    return (v >> k) | (v << (6'd32 - {1'b0, k}));
  endfunction

  // Returns {carry, result}; shifting a 33-bit value keeps the last bit shifted out in the spare bit.
  function automatic logic [32:0] shift_fn(input logic [31:0] rm, input logic [11:0] op,
                                           input logic im, input logic mem, input logic rsh,
                                           input logic cin, input logic [7:0] rs_amt);
    logic [7:0]  n;
    logic [32:0] t;
    logic [31:0] r;
    n = rsh ? rs_amt : {3'b0, op[11:7]};
    if (mem) return {cin, 20'b0, op};
    if (im) begin
      r = ror32({24'b0, op[7:0]}, {op[11:8], 1'b0});
      return {(op[11:8] != 4'd0) ? r[31] : cin, r};
    end
    if (n == 8'd0) return {cin, rm};
    case (op[6:5])
      2'b00: begin
        t = {1'b0, rm} << n;
        return t;
      end
      2'b01: begin
        t = {rm, 1'b0} >> n;
        return {t[0], t[32:1]};
      end
      2'b10: begin
        t = $signed({rm, 1'b0}) >>> n;
        return {t[0], t[32:1]};
      end
      default: begin
        r = ror32(rm, n[4:0]);
        return {r[31], r};
      end
    endcase
  endfunction

  always_comb begin
    acc      = (state_q == IDLE) && req_valid;
    rsh_live = reg_shift & ~mem_op & ~imm;
    rm_d     = acc ? val_rm : rm_q;
    op_d     = acc ? shift_operand : op_q;
    imm_d    = acc ? imm : imm_q;
    mem_d    = acc ? mem_op : mem_q;
    rsh_d    = acc ? rsh_live : rsh_q;
    cin_d    = acc ? cin_live : cin_q;
    load     = (acc && !(rsh_live && !rs_valid)) || ((state_q == WAIT_RS) && rs_valid);
    sh       = shift_fn(rm_d, op_d, imm_d, mem_d, rsh_d, cin_d, rs_value[7:0]);
    val2_d   = load ? sh[31:0] : val2_q;
    carry_d  = load ? (CARRY_EN & sh[32]) : carry_q;
    state_d  = state_q;
    case (state_q)
      IDLE:    state_d = !req_valid ? IDLE : (rsh_live && !rs_valid) ? WAIT_RS : DONE;
      WAIT_RS: state_d = rs_valid ? DONE : WAIT_RS;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rm_q    <= '0;
      op_q    <= '0;
      imm_q   <= 1'b0;
      mem_q   <= 1'b0;
      rsh_q   <= 1'b0;
      cin_q   <= 1'b0;
      val2_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rm_q    <= rm_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      mem_q   <= mem_d;
      rsh_q   <= rsh_d;
      cin_q   <= cin_d;
      val2_q  <= val2_d;
      carry_q <= carry_d;
    end
  end

  assign req_ready  = state_q == IDLE;
  assign stall      = state_q == WAIT_RS;
  assign val2_valid = state_q == DONE;
  assign val2       = val2_q;
  assign carry_out  = carry_q;
endmodule

// File: tb/tb_val2_shift_ctrl.sv
// tb_val2_shift_ctrl: directed vectors with hand-computed Val2/carry results for val2_shift_ctrl.
module tb_val2_shift_ctrl;
`ifdef VAL2_SHIFT_CARRY_EN
  localparam logic CEN = 1'b1;
`else
  localparam logic CEN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_ready;
  logic [31:0] val_rm = '0, rs_value = '0, val2;
  logic [11:0] shift_operand = '0;
  logic        imm = 1'b0, mem_op = 1'b0, reg_shift = 1'b0, carry_in = 1'b0;
  logic        rs_valid = 1'b0, out_ready = 1'b0, val2_valid, carry_out, stall;
  int          vecs = 0, errs = 0;

  val2_shift_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .val_rm(val_rm), .shift_operand(shift_operand), .imm(imm), .mem_op(mem_op),
    .reg_shift(reg_shift), .carry_in(carry_in), .rs_value(rs_value), .rs_valid(rs_valid),
    .out_ready(out_ready), .val2(val2), .val2_valid(val2_valid), .carry_out(carry_out),
    .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] rm, input logic [11:0] op, input logic im,
                      input logic mem, input logic rsh, input logic cin,
                      input logic rsv, input logic [31:0] rsval);
    val_rm = rm; shift_operand = op; imm = im; mem_op = mem; reg_shift = rsh;
    carry_in = cin; rs_valid = rsv; rs_value = rsval; req_valid = 1'b1;
    step();
    req_valid = 1'b0; rs_valid = 1'b0;
  endtask

  task automatic expect_done(input string tag, input logic [31:0] v, input logic c);
    chk({tag, "_valid"}, {31'b0, val2_valid}, 32'd1);
    chk({tag, "_val2"}, val2, v);
    chk({tag, "_carry"}, {31'b0, carry_out}, {31'b0, CEN & c});
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd0);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, {31'b0, val2_valid}, 32'd0);
    chk({tag, "_idle_ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_val2", val2, 32'd0);
    chk("rst_valid", {31'b0, val2_valid}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_carry", {31'b0, carry_out}, 32'd0);
    rst = 1'b0;
    step();
    chk("rst_ready", {31'b0, req_ready}, 32'd1);

    send(32'h1234_5678, 12'hABC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    expect_done("mem", 32'h0000_0ABC, 1'b1);
    // Handoff cycle: a request presented with out_ready must wait for IDLE.
    val_rm = '0; shift_operand = 12'h123; mem_op = 1'b1; carry_in = 1'b0; req_valid = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("handoff_valid", {31'b0, val2_valid}, 32'd0);
    chk("handoff_ready", {31'b0, req_ready}, 32'd1);
    chk("handoff_hold", val2, 32'h0000_0ABC);
    step();
    req_valid = 1'b0;
    expect_done("mem2", 32'h0000_0123, 1'b0);
    release_out("mem2");

    send(32'h0, 12'h4FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    expect_done("imm", 32'hFF00_0000, 1'b1);
    release_out("imm");

    send(32'h8000_0000, 12'h050, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("asr_stall", {31'b0, stall}, 32'd1);
      chk("asr_wait_valid", {31'b0, val2_valid}, 32'd0);
      if (i < 2) step();
    end
    rs_value = 32'd40; rs_valid = 1'b1;
    step();
    rs_valid = 1'b0;
    chk("asr_stall_off", {31'b0, stall}, 32'd0);
    expect_done("asr40", 32'hFFFF_FFFF, 1'b1);
    release_out("asr40");

    send(32'h0000_000F, 12'h260, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      expect_done("ror4", 32'hF000_0000, 1'b1);
      step();
    end
    release_out("ror4");

    send(32'h1234_5678, 12'h020, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    expect_done("lsr0", 32'h1234_5678, 1'b1);
    release_out("lsr0");

    send(32'h0000_0001, 12'h010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd32);
    expect_done("lsl32", 32'h0, 1'b1);
    release_out("lsl32");

    send(32'h8000_0001, 12'h030, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd32);
    expect_done("lsr32", 32'h0, 1'b1);
    release_out("lsr32");

    send(32'hFFFF_FFFF, 12'h030, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd33);
    expect_done("lsr33", 32'h0, 1'b0);
    release_out("lsr33");

    send(32'h0000_000F, 12'h070, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0124);
    expect_done("ror36", 32'hF000_000F & 32'hF000_0000, 1'b1);
    release_out("ror36");

    send(32'hCAFE_F00D, 12'h050, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
    expect_done("asr0", 32'hCAFE_F00D, 1'b1);
    release_out("asr0");

    send(32'h0000_0001, 12'h010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("rstw_stall", {31'b0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw_valid", {31'b0, val2_valid}, 32'd0);
    chk("rstw_stall_off", {31'b0, stall}, 32'd0);
    chk("rstw_val2", val2, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rstw_ready", {31'b0, req_ready}, 32'd1);
    send(32'h0000_0001, 12'hF80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    expect_done("lsl31", 32'h8000_0000, 1'b0);
    release_out("lsl31");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
